// File: rtl/past_sequence_decoder.sv
// past_sequence_decoder
//   Receive-side inverse of the past-sequence (sliding-window) adder. Takes
//   the stream of window sums s(t) = x(t)+...+x(t-2^N+1) (mod 2^data_width)
//   and recovers x(t) = s(t) - s(t-1) + x(t-2^N).
//
//   The decoder starts from zero history, as the adder does. One sample is
//   accepted per valid cycle. The recovered sample appears one cycle later.
//
// Parameters
//   data_width  width of the window sums and the recovered samples
//   N           window depth is 2^N samples (must match the adder)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   in_sum carries a new window sum this cycle
//   in_sum     window sum s(t) from the adder
//   out_valid  out_inp carries a recovered sample
//   out_inp    recovered sample x(t)
//   primed     high once 2^N samples have been decoded since reset/flush
//   flush      present only when PAST_SEQ_DEC_FLUSH_EN is defined;
//              synchronously clears the decoding history
//
// Build option
//   PAST_SEQ_DEC_FLUSH_EN  adds the flush port. Without it, only rst
//                          clears state.
module past_sequence_decoder #(
  parameter int data_width = 10,
  parameter int N          = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [data_width-1:0] in_sum,
`ifdef PAST_SEQ_DEC_FLUSH_EN
  input  logic                  flush,
`endif
  output logic                  out_valid,
  output logic [data_width-1:0] out_inp,
  output logic                  primed
);

  localparam int unsigned DEPTH = 2 ** N;
  localparam logic [N:0]  FULL  = (N+1)'(DEPTH);

  logic [data_width-1:0] hist [DEPTH];
  logic [data_width-1:0] s_prev;
  logic [N-1:0]          wp;
  logic [N:0]            count;

  logic                  flush_now;
  logic [data_width-1:0] s_base;
  logic [data_width-1:0] h_base;
  logic [N-1:0]          wp_base;
  logic [N:0]            count_base;
  logic [data_width-1:0] x_next;

`ifdef PAST_SEQ_DEC_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  // A flush on the same edge as a valid sample decodes that sample against
  // the cleared state. Therefore every operand is taken from its
  // post-flush value.
  always_comb begin
    s_base     = s_prev;
    h_base     = hist[wp];
    wp_base    = wp;
    count_base = count;
    if (flush_now) begin
      s_base     = '0;
      h_base     = '0;
      wp_base    = '0;
      count_base = '0;
    end
    x_next = in_sum - s_base + h_base;
  end

  // The count saturates at exactly 2^N. Therefore its MSB is the primed flag.
  assign primed = count[N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_inp   <= '0;
      s_prev    <= '0;
      wp        <= '0;
      count     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        hist[i] <= '0;
      end
    end else begin
      out_valid <= in_valid;
      if (flush_now) begin
        s_prev <= '0;
        wp     <= '0;
        count  <= '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
          hist[i] <= '0;
        end
      end
      // The later assignments override the flush clears above. The entry
      // at wp_base is read for x_next before it is overwritten with x_next.
      if (in_valid) begin
        out_inp       <= x_next;
        hist[wp_base] <= x_next;
        wp            <= wp_base + 1'b1;
        s_prev        <= in_sum;
        if (count_base != FULL) begin
          count <= count_base + 1'b1;
        end else begin
          count <= count_base;
        end
      end
    end
  end

endmodule
